// File: rtl/tt_micro_tile_mux_if.sv
// rtl/tt_micro_tile_mux_if.sv - shared bus between the tile mux and its attached micro projects
interface tt_micro_tile_mux_if #(
    parameter int N_PROJ = 8
);
    logic [7:0]          proj_ui;
    logic [N_PROJ-1:0]   proj_rst_n;
    logic [8*N_PROJ-1:0] proj_uo;

    modport master (
        output proj_ui,
        output proj_rst_n,
        input  proj_uo
    );

    modport slave (
        input  proj_ui,
        input  proj_rst_n,
        output proj_uo
    );
endinterface

// File: rtl/tt_micro_tile_mux.sv
// rtl/tt_micro_tile_mux.sv - micro-tile project selector and reset sequencer (option: TT_MICRO_MUX_AUTOSTART_EN)
module tt_micro_tile_mux #(
    parameter int N_PROJ     = 8,
    parameter int RST_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0]            ui_in,
    input  logic                  sel_load,
    tt_micro_tile_mux_if.master   proj,
    output logic [7:0]            uo_out,
    output logic                  busy
);
    localparam int CW = $clog2(RST_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(RST_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RESET, RUN} state_t;

    state_t        state, state_next;
    logic [3:0]    sel, sel_next;
    logic [CW-1:0] cnt, cnt_next;
    logic [7:0]    uo_next;
    logic          idx_ok;

    assign idx_ok = {1'b0, ui_in[3:0]} < 5'(N_PROJ);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
`ifdef TT_MICRO_MUX_AUTOSTART_EN
            state <= RESET;
            cnt   <= CNT_LOAD;
`else
            state <= IDLE;
            cnt   <= '0;
`endif
            sel    <= 4'd0;
            uo_out <= 8'h00;
        end else begin
            state  <= state_next;
            cnt    <= cnt_next;
            sel    <= sel_next;
            uo_out <= uo_next;
        end
    end

    // A load strobe wins over counter expiry, from any state.
    always_comb begin
        state_next = state;
        sel_next   = sel;
        cnt_next   = cnt;
        if (sel_load) begin
            sel_next = ui_in[3:0];
            if (idx_ok) begin
                state_next = RESET;
                cnt_next   = CNT_LOAD;
            end else begin
                state_next = IDLE;
            end
        end else begin
            case (state)
                RESET: begin
                    if (cnt == '0) state_next = RUN;
                    else           cnt_next   = cnt - CW'(1);
                end
                default: state_next = state;
            endcase
        end
    end

    // Project resets and busy come from registered state only; uo_out only
    // follows the project while it stays in RUN across the edge.
    always_comb begin
        proj.proj_ui    = 8'h00;
        proj.proj_rst_n = '0;
        busy            = (state == RESET);
        uo_next         = 8'h00;
        if (state == RUN) begin
            proj.proj_ui = ui_in;
            for (int i = 0; i < N_PROJ; i++) begin
                if (sel == 4'(i)) proj.proj_rst_n[i] = 1'b1;
            end
            if (state_next == RUN) begin
                for (int i = 0; i < N_PROJ; i++) begin
                    if (sel == 4'(i)) uo_next = proj.proj_uo[8*i +: 8];
                end
            end
        end
    end
endmodule
